// File: rtl/arbitro_memoria_dados.sv
// arbitro_memoria_dados: two-port round-robin arbiter/sequencer for the data memory.
// Port 0 is the core load/store unit, port 1 the loader/debug master. One transaction
// in flight, byte-lane mask from size/address, misalignment detection, registered outputs.
// Optional watchdog on the memory wait: define ARBITRO_MEMORIA_DADOS_TIMEOUT_EN.
module arbitro_memoria_dados #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [1:0]        tam0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic              err0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [1:0]        tam1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic              err1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_mask,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              ocupado
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              last_q, last_d;
  logic              sel_q, sel_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_mask_q, mem_mask_d;
  logic              ack0_q, ack0_d, ack1_q, ack1_d;
  logic              err0_q, err0_d, err1_q, err1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic              ocupado_q, ocupado_d;

`ifdef ARBITRO_MEMORIA_DADOS_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Selected-port fields and response staging (combinational helpers)
  logic              pick;
  logic              f_we;
  logic [1:0]        f_tam;
  logic [ADDR_W-1:0] f_addr;
  logic [DATA_W-1:0] f_wdata;
  logic              resp_go;
  logic              resp_err;
  logic [DATA_W-1:0] resp_data;

  function automatic logic is_illegal(input logic [1:0] tam, input logic [1:0] lsb);
    case (tam)
      2'b00:   is_illegal = 1'b0;
      2'b01:   is_illegal = lsb[0];
      2'b10:   is_illegal = (lsb != 2'b00);
      default: is_illegal = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] tam, input logic [1:0] lsb);
    case (tam)
      2'b00:   lane_mask = 4'b0001 << lsb;
      2'b01:   lane_mask = lsb[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  // Next-state: arbitration in IDLE, memory wait in ISSUE, one-cycle response in RESP
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    sel_d       = sel_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_mask_d  = mem_mask_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    err0_d      = 1'b0;
    err1_d      = 1'b0;
    rdata0_d    = '0;
    rdata1_d    = '0;
    pick        = 1'b0;
    f_we        = 1'b0;
    f_tam       = 2'b00;
    f_addr      = '0;
    f_wdata     = '0;
    resp_go     = 1'b0;
    resp_err    = 1'b0;
    resp_data   = '0;
`ifdef ARBITRO_MEMORIA_DADOS_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // Under contention the port that was not served last wins
          pick    = (req0 && req1) ? ~last_q : req1;
          f_we    = pick ? we1    : we0;
          f_tam   = pick ? tam1   : tam0;
          f_addr  = pick ? addr1  : addr0;
          f_wdata = pick ? wdata1 : wdata0;
          sel_d   = pick;
          if (is_illegal(f_tam, f_addr[1:0])) begin
            // Rejected without touching memory; still counts as served
            resp_go  = 1'b1;
            resp_err = 1'b1;
            state_d  = RESP;
          end else begin
            state_d     = ISSUE;
            mem_req_d   = 1'b1;
            mem_we_d    = f_we;
            mem_addr_d  = {f_addr[ADDR_W-1:2], 2'b00};
            mem_wdata_d = f_wdata;
            mem_mask_d  = lane_mask(f_tam, f_addr[1:0]);
`ifdef ARBITRO_MEMORIA_DADOS_TIMEOUT_EN
            cnt_d       = '0;
`endif
          end
        end
      end
      ISSUE: begin
        if (mem_ack) begin
          resp_go   = 1'b1;
          resp_data = mem_we_q ? '0 : mem_rdata;
          state_d   = RESP;
`ifdef ARBITRO_MEMORIA_DADOS_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          resp_go  = 1'b1;
          resp_err = 1'b1;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
        if (state_d == RESP) begin
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          mem_mask_d  = '0;
        end
      end
      RESP: begin
        state_d = IDLE;
        last_d  = sel_q;
      end
      default: state_d = IDLE;
    endcase

    if (resp_go) begin
      if (sel_d) begin
        ack1_d   = 1'b1;
        err1_d   = resp_err;
        rdata1_d = resp_data;
      end else begin
        ack0_d   = 1'b1;
        err0_d   = resp_err;
        rdata0_d = resp_data;
      end
    end

    ocupado_d = (state_d != IDLE);
  end

  // State and output registers; reset abandons any transaction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      sel_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_mask_q  <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      ocupado_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      sel_q       <= sel_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_mask_q  <= mem_mask_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      err0_q      <= err0_d;
      err1_q      <= err1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      ocupado_q   <= ocupado_d;
    end
  end

`ifdef ARBITRO_MEMORIA_DADOS_TIMEOUT_EN
  // Watchdog counter of ISSUE cycles spent without mem_ack
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_mask  = mem_mask_q;
  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign err0      = err0_q;
  assign err1      = err1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign ocupado   = ocupado_q;

endmodule

// File: tb/tb_arbitro_memoria_dados.sv
// Randomized bench for arbitro_memoria_dados against a transaction-level reference model.
module tb_arbitro_memoria_dados;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, we0, req1, we1;
  logic [1:0]  tam0, tam1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, err0, ack1, err1;
  logic [31:0] rdata0, rdata1;
  logic        mem_req, mem_we, mem_ack, ocupado;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_mask;

  always #5 clk = ~clk;

  // Requester state: pending flag and fields held until ack
  logic        rq    [2];
  logic        r_we  [2];
  logic [1:0]  r_tam [2];
  logic [31:0] r_addr[2];
  logic [31:0] r_wdat[2];

  assign req0 = rq[0];  assign we0 = r_we[0];  assign tam0 = r_tam[0];
  assign addr0 = r_addr[0];  assign wdata0 = r_wdat[0];
  assign req1 = rq[1];  assign we1 = r_we[1];  assign tam1 = r_tam[1];
  assign addr1 = r_addr[1];  assign wdata1 = r_wdat[1];

  arbitro_memoria_dados #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .tam0(tam0), .addr0(addr0), .wdata0(wdata0),
    .ack0(ack0), .err0(err0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .tam1(tam1), .addr1(addr1), .wdata1(wdata1),
    .ack1(ack1), .err1(err1), .rdata1(rdata1),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_mask(mem_mask), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ocupado(ocupado)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Access size in bytes is 1 << tam; legal when naturally aligned
  function automatic bit legal(input logic [1:0] tam, input logic [31:0] a);
    int nbytes;
    if (tam == 2'b11) return 1'b0;
    nbytes = 1 << tam;
    return (a % nbytes) == 0;
  endfunction

  function automatic logic [3:0] exp_mask(input logic [1:0] tam, input logic [31:0] a);
    int nbytes;
    int lanes;
    nbytes = 1 << tam;
    lanes  = ((1 << nbytes) - 1) << (a % 4);
    return 4'(lanes);
  endfunction

  task automatic new_req(input int p);
    rq[p]     = 1'b1;
    r_we[p]   = 1'($urandom_range(0, 1));
    r_tam[p]  = ($urandom_range(0, 7) < 6) ? 2'($urandom_range(0, 2)) : 2'b11;
    r_addr[p] = $urandom & 32'h0000_03FF;
    r_wdat[p] = $urandom;
  endtask

  // Reference model: phase 0 waiting to sample, 1 memory access, 2 response cycle
  int          ph;
  int          m_last;
  int          m_sel;
  logic        m_err;
  logic [31:0] m_data;
  int          m_wait;
  bit          did_rst;
  bit          give;

  initial begin
    rst = 1'b1;
    mem_ack = 1'b0;
    mem_rdata = '0;
    for (int p = 0; p < 2; p++) begin
      rq[p] = 1'b0; r_we[p] = 1'b0; r_tam[p] = 2'b00; r_addr[p] = '0; r_wdat[p] = '0;
    end
    ph = 0; m_last = 1; m_sel = 0; m_err = 1'b0; m_data = '0; m_wait = 0; did_rst = 1'b0;
    #12;
    check("reset_ack0", {31'b0, ack0}, 32'd0);
    check("reset_ack1", {31'b0, ack1}, 32'd0);
    check("reset_mem_req", {31'b0, mem_req}, 32'd0);
    check("reset_ocupado", {31'b0, ocupado}, 32'd0);
    check("reset_rdata0", rdata0, 32'd0);
    check("reset_mem_mask", {28'b0, mem_mask}, 32'd0);
    // First contention after reset must go to port 0
    new_req(0);
    new_req(1);

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (rst) rst = 1'b0;

      case (ph)
        0: begin
          check("idle_ocupado", {31'b0, ocupado}, 32'd0);
          check("idle_mem_req", {31'b0, mem_req}, 32'd0);
          check("idle_acks", {30'b0, ack1, ack0}, 32'd0);
        end
        1: begin
          check("issue_ocupado", {31'b0, ocupado}, 32'd1);
          check("issue_mem_req", {31'b0, mem_req}, 32'd1);
          check("issue_mem_we", {31'b0, mem_we}, {31'b0, r_we[m_sel]});
          check("issue_mem_addr", mem_addr, r_addr[m_sel] & 32'hFFFF_FFFC);
          check("issue_mem_wdata", mem_wdata, r_wdat[m_sel]);
          check("issue_mem_mask", {28'b0, mem_mask},
                {28'b0, exp_mask(r_tam[m_sel], r_addr[m_sel])});
          check("issue_acks", {30'b0, ack1, ack0}, 32'd0);
        end
        default: begin
          check("resp_ocupado", {31'b0, ocupado}, 32'd1);
          check("resp_mem_req", {31'b0, mem_req}, 32'd0);
          check("resp_acks", {30'b0, ack1, ack0}, (m_sel == 1) ? 32'd2 : 32'd1);
          check("resp_errs", {30'b0, err1, err0},
                m_err ? ((m_sel == 1) ? 32'd2 : 32'd1) : 32'd0);
          check("resp_rdata_sel", (m_sel == 1) ? rdata1 : rdata0, m_data);
          check("resp_rdata_other", (m_sel == 1) ? rdata0 : rdata1, 32'd0);
        end
      endcase

      // Asynchronous reset while the memory access is outstanding
      if (!did_rst && cyc > 2000 && ph == 1) begin
        rst = 1'b1;
        #1;
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_acks", {30'b0, ack1, ack0}, 32'd0);
        check("rst_ocupado", {31'b0, ocupado}, 32'd0);
        did_rst = 1'b1;
        ph = 0;
        m_last = 1;
        mem_ack = 1'b0;
        if (!rq[0]) new_req(0);
        if (!rq[1]) new_req(1);
        continue;
      end

      // Requesters: drop after ack, then possibly issue something new
      if (ph == 2) rq[m_sel] = 1'b0;
      for (int p = 0; p < 2; p++) begin
        if (!rq[p] && $urandom_range(0, 2) == 0) new_req(p);
      end

      // Memory: random wait states, occasional stray acks outside an access
      mem_rdata = $urandom;
      if (ph == 1) begin
        give = ($urandom_range(0, 2) == 0);
`ifndef ARBITRO_MEMORIA_DADOS_TIMEOUT_EN
        if (m_wait >= 6) give = 1'b1;
`endif
        mem_ack = give;
      end else begin
        mem_ack = ($urandom_range(0, 7) == 0);
      end

      case (ph)
        0: begin
          if (rq[0] || rq[1]) begin
            if (rq[0] && rq[1]) m_sel = 1 - m_last;
            else m_sel = rq[1] ? 1 : 0;
            if (legal(r_tam[m_sel], r_addr[m_sel])) begin
              ph = 1;
              m_wait = 0;
            end else begin
              ph = 2;
              m_err = 1'b1;
              m_data = '0;
            end
          end
        end
        1: begin
          m_wait++;
          if (mem_ack) begin
            ph = 2;
            m_err = 1'b0;
            m_data = r_we[m_sel] ? 32'd0 : mem_rdata;
          end
`ifdef ARBITRO_MEMORIA_DADOS_TIMEOUT_EN
          else if (m_wait == TO) begin
            ph = 2;
            m_err = 1'b1;
            m_data = '0;
          end
`endif
        end
        default: begin
          m_last = m_sel;
          ph = 0;
        end
      endcase
    end

    check("reset_injected", {31'b0, did_rst}, 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
